ifetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the control decoder.
- Owns the PC register and fetches words from instruction memory over a req/ack handshake.
- Presents the held instruction, with opcode/func split out, to the decoder.
- Consumes the decoder's PC_sel/IsJump outputs and the ALU branch result to compute and latch the next PC.

---
 rtl/ifetch_unit_if.sv | 22 ++
 rtl/ifetch_unit.sv | 125 ++++++++++++
 tb/tb_ifetch_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, ack/data back.
// The fetch side holds imem_req until it sees imem_ack.
interface ifetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, fetches over imem req/ack, holds instr for decode (ack + 1 cycle).
// stall freezes the held instruction; a missing ack for IMEM_TIMEOUT cycles halts with err[1].
module ifetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_3000,
   parameter int          IMEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rstn,
   ifetch_unit_if.master       imem,
   input  logic                stall,
   input  logic [1:0]          pc_sel,
   input  logic [1:0]          is_jump,
   input  logic                branch_taken,
   input  logic [31:0]         jr_target,
   output logic [31:0]         instr,
   output logic [5:0]          opcode,
   output logic [5:0]          func,
   output logic                instr_valid,
   output logic [31:0]         pc,
   output logic [31:0]         pc_plus4,
   output logic [1:0]          err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_VALID = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam int            CW       = $clog2(IMEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(IMEM_TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   instr_q, instr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    err_q, err_d;

   logic [31:0]   pc_plus4_w;
   logic [31:0]   br_off;
   logic [31:0]   next_pc;
   logic          jr_misaligned;

   assign pc_plus4_w    = pc_q + 32'd4;
   assign br_off        = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign jr_misaligned = (is_jump == 2'd3) && (jr_target[1:0] != 2'b00);

   // Jumps outrank branches; pc_sel values other than 01 fall through to sequential.
   always_comb begin
      next_pc = pc_plus4_w;
      if (is_jump == 2'd3) begin
         next_pc = {jr_target[31:2], 2'b00};
      end else if (is_jump != 2'd0) begin
         next_pc = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
      end else if ((pc_sel == 2'b01) && branch_taken) begin
         next_pc = pc_plus4_w + br_off;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d   = '0;
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (imem.imem_ack) begin
               instr_d = imem.imem_rdata;
               cnt_d   = '0;
               state_d = ST_VALID;
            end else if (cnt_q == CNT_LAST) begin
               err_d[1] = 1'b1;
               state_d  = ST_HALT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_VALID: begin
            if (!stall) begin
               pc_d    = next_pc;
               cnt_d   = '0;
               state_d = ST_REQ;
               if (jr_misaligned) begin
                  err_d[0] = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         cnt_q   <= '0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Outputs decode straight from the state register so reset drops imem_req at once.
   assign imem.imem_req  = (state_q == ST_REQ);
   assign imem.imem_addr = pc_q;
   assign instr_valid    = (state_q == ST_VALID);
   assign instr          = instr_q;
   assign opcode         = instr_q[31:26];
   assign func           = instr_q[5:0];
   assign pc             = pc_q;
   assign pc_plus4       = pc_plus4_w;
   assign err            = err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: stimulus queues expected fetches, a negedge monitor checks them.
module tb_ifetch_unit;
   logic        clk = 1'b0;
   logic        rstn;
   logic        stall;
   logic [1:0]  pc_sel;
   logic [1:0]  is_jump;
   logic        branch_taken;
   logic [31:0] jr_target;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [1:0]  err;

   ifetch_unit_if imem_bus ();

   ifetch_unit dut (
      .clk          (clk),
      .rstn         (rstn),
      .imem         (imem_bus),
      .stall        (stall),
      .pc_sel       (pc_sel),
      .is_jump      (is_jump),
      .branch_taken (branch_taken),
      .jr_target    (jr_target),
      .instr        (instr),
      .opcode       (opcode),
      .func         (func),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .err          (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] addr_q[$];
   exp_t        valid_q[$];
   logic [31:0] mon_a;
   exp_t        mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a fetch handshake pops an address, a consumed instruction pops a record.
   always @(negedge clk) begin
      if (rstn) begin
         if (imem_bus.imem_req && imem_bus.imem_ack) begin
            if (addr_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_fetch: got addr %h expected none", imem_bus.imem_addr);
            end else begin
               mon_a = addr_q.pop_front();
               chk("fetch_addr", imem_bus.imem_addr, mon_a);
            end
         end
         if (instr_valid && !stall) begin
            if (valid_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_valid: got instr %h expected none", instr);
            end else begin
               mon_e = valid_q.pop_front();
               chk("instr",    instr, mon_e.instr);
               chk("opcode",   32'(opcode), 32'(mon_e.instr[31:26]));
               chk("func",     32'(func), 32'(mon_e.instr[5:0]));
               chk("pc",       pc, mon_e.pc);
               chk("pc_plus4", pc_plus4, mon_e.pc + 32'd4);
            end
         end
      end
   end

   task automatic wait_req();
      int n = 0;
      while (!imem_bus.imem_req && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!imem_bus.imem_req) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_req: got no imem_req after %0d cycles expected a request", n);
      end
   endtask

   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rdata, input int dly,
                           input int nstall, input logic [1:0] psel, input logic [1:0] ij,
                           input logic bt, input logic [31:0] jrt);
      addr_q.push_back(addr);
      valid_q.push_back(exp_t'({addr, rdata}));
      wait_req();
      repeat (dly) begin
         @(posedge clk);
         #1;
      end
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = rdata;
      @(posedge clk);
      #1;
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 32'hBAD0_BAD0;
      chk("valid_after_ack", 32'(instr_valid), 32'd1);
      if (nstall > 0) begin
         stall        = 1'b1;
         pc_sel       = 2'b01;
         branch_taken = 1'b1;
         is_jump      = 2'd3;
         jr_target    = 32'h0000_7777;
         for (int i = 0; i < nstall; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", pc, addr);
            chk("stall_instr", instr, rdata);
         end
      end
      pc_sel       = psel;
      is_jump      = ij;
      branch_taken = bt;
      jr_target    = jrt;
      stall        = 1'b0;
      @(posedge clk);
      #1;
      pc_sel       = 2'b00;
      is_jump      = 2'd0;
      branch_taken = 1'b0;
      jr_target    = 32'h0;
      chk("valid_drop", 32'(instr_valid), 32'd0);
      chk("refetch_req", 32'(imem_bus.imem_req), 32'd1);
   endtask

   initial begin
      rstn                = 1'b0;
      stall               = 1'b0;
      pc_sel              = 2'b00;
      is_jump             = 2'd0;
      branch_taken        = 1'b0;
      jr_target           = 32'h0;
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",   32'(imem_bus.imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc",    pc, 32'h0000_3000);
      chk("rst_err",   32'(err), 32'd0);
      rstn = 1'b1;

      // addr, rdata, ack delay, stall cycles, pc_sel, is_jump, branch_taken, jr_target
      do_fetch(32'h0000_3000, 32'h3C01_1234, 1, 0, 2'b00, 2'd0, 1'b0, 32'h0);
      do_fetch(32'h0000_3004, 32'h0000_0000, 0, 0, 2'b00, 2'd0, 1'b0, 32'h0);
      do_fetch(32'h0000_3008, 32'h1000_FFFE, 2, 0, 2'b01, 2'd0, 1'b1, 32'h0);
      do_fetch(32'h0000_3004, 32'h0000_0000, 0, 0, 2'b00, 2'd0, 1'b0, 32'h0);
      do_fetch(32'h0000_3008, 32'h1000_FFFE, 0, 0, 2'b01, 2'd0, 1'b0, 32'h0);
      do_fetch(32'h0000_300C, 32'h1000_FFFE, 0, 0, 2'b10, 2'd0, 1'b1, 32'h0);
      do_fetch(32'h0000_3010, 32'h0800_0C10, 0, 5, 2'b00, 2'd1, 1'b0, 32'h0);
      do_fetch(32'h0000_3040, 32'h0C00_0C14, 0, 0, 2'b00, 2'd2, 1'b0, 32'h0);
      chk("err_after_stall", 32'(err), 32'd0);
      do_fetch(32'h0000_3050, 32'h03E0_0008, 0, 0, 2'b00, 2'd3, 1'b0, 32'h0000_4006);
      chk("err_misaligned_jr", 32'(err), 32'd1);
      do_fetch(32'h0000_4004, 32'h03E0_0008, 0, 0, 2'b00, 2'd3, 1'b0, 32'hFFFF_FFFC);
      chk("err_sticky_jr", 32'(err), 32'd1);
      do_fetch(32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 2'b00, 2'd0, 1'b0, 32'h0);

      chk("wrap_addr", imem_bus.imem_addr, 32'h0);
      repeat (15) @(posedge clk);
      #1;
      chk("req_before_timeout", 32'(imem_bus.imem_req), 32'd1);
      chk("err_before_timeout", 32'(err), 32'd1);
      @(posedge clk);
      #1;
      chk("err_timeout", 32'(err), 32'd3);
      chk("halt_req", 32'(imem_bus.imem_req), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      imem_bus.imem_ack = 1'b0;
      chk("halt_ack_ignored", instr, 32'h0);
      chk("halt_hold_req", 32'(imem_bus.imem_req), 32'd0);

      rstn = 1'b0;
      #1;
      chk("rst2_err",   32'(err), 32'd0);
      chk("rst2_pc",    pc, 32'h0000_3000);
      chk("rst2_valid", 32'(instr_valid), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("rst2_req", 32'(imem_bus.imem_req), 32'd1);
      #3;
      rstn = 1'b0;
      #1;
      chk("req_async_drop", 32'(imem_bus.imem_req), 32'd0);
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      imem_bus.imem_ack = 1'b0;
      chk("late_ack_instr", instr, 32'h0);
      chk("late_ack_valid", 32'(instr_valid), 32'd0);
      chk("late_ack_req", 32'(imem_bus.imem_req), 32'd1);
      do_fetch(32'h0000_3000, 32'h3C01_1234, 0, 0, 2'b00, 2'd0, 1'b0, 32'h0);

      chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
      chk("valid_q_drained", 32'(valid_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
